// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - MEM stage controller: data-memory access, PC redirect, MEM/WB register
//
// Purpose: consumes the EX/MEM pipeline register, runs one data-memory access per
// load/store over a req/ack bus with wait states and a timeout, resolves the
// branch/jump redirect and loads the MEM/WB pipeline register.
//
// Ports:
//   clkMEMWB, rstMEMWB_n         clock (rising edge), asynchronous active-low reset
//   Wb2, Branch, MemRead,        EX/MEM control
//   MemWrite, jump_out
//   tMux32, ZFtAND, AluRes,      EX/MEM data: branch target, zero flag, ALU result,
//   tWriteData, toMEMWB,         store data, destination register, jump target
//   jaddress_out
//   dmem_rdata, dmem_ack         data-memory response (ack is a one-cycle pulse)
//   err_clr                      clears the sticky bus_err flag
//   dmem_req/we/addr/wdata       registered data-memory request
//   PCSrc, pc_target             PC mux redirect (combinational)
//   stall_mem                    freezes IF/ID/EX and EX/MEM
//   Wb3, ReadData, AluResWB,     MEM/WB pipeline register
//   rdWB
//   bus_err                      sticky misalignment/timeout error

module mem_stage_ctrl #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 8
) (
    input  logic        clkMEMWB,
    input  logic        rstMEMWB_n,
    input  logic [1:0]  Wb2,
    input  logic        Branch,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] tMux32,
    input  logic        ZFtAND,
    input  logic [31:0] AluRes,
    input  logic [31:0] tWriteData,
    input  logic [4:0]  toMEMWB,
    input  logic        jump_out,
    input  logic [31:0] jaddress_out,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    input  logic        err_clr,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic        PCSrc,
    output logic [31:0] pc_target,
    output logic        stall_mem,
    output logic [1:0]  Wb3,
    output logic [31:0] ReadData,
    output logic [31:0] AluResWB,
    output logic [4:0]  rdWB,
    output logic        bus_err
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        wb3_q, wb3_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [31:0]       alu_q, alu_d;
    logic [4:0]        rd_q, rd_d;
    logic              err_q, err_d;
    logic              err_set;

    logic access;
    logic misaligned;

    assign access     = MemRead | MemWrite;
    assign misaligned = access & (AluRes[1:0] != 2'b00);

    // Redirect is purely combinational; jump wins over a taken branch.
    assign PCSrc     = jump_out | (Branch & ZFtAND);
    assign pc_target = jump_out ? jaddress_out : tMux32;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        done_d    = done_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wb3_d     = wb3_q;
        rdata_d   = rdata_q;
        alu_d     = alu_q;
        rd_d      = rd_q;
        err_set   = 1'b0;
        stall_mem = 1'b0;

        case (state_q)
            IDLE: begin
                if (done_q) begin
                    // EX/MEM still shows the instruction just served: emit a bubble
                    // and wait for the pipeline to advance.
                    wb3_d  = 2'b00;
                    done_d = 1'b0;
                end else if (misaligned) begin
                    err_set = 1'b1;
                    wb3_d   = 2'b00;
                    alu_d   = AluRes;
                    rd_d    = toMEMWB;
                end else if (access) begin
                    stall_mem = 1'b1;
                    req_d     = 1'b1;
                    we_d      = MemWrite;
                    addr_d    = AluRes;
                    wdata_d   = tWriteData;
                    cnt_d     = '0;
                    wb3_d     = 2'b00;
                    alu_d     = AluRes;
                    rd_d      = toMEMWB;
                    state_d   = BUSY;
                end else begin
                    wb3_d = Wb2;
                    alu_d = AluRes;
                    rd_d  = toMEMWB;
                end
            end

            BUSY: begin
                stall_mem = 1'b1;
                // Ack is checked first so it wins over a simultaneous timeout.
                if (dmem_ack) begin
                    req_d   = 1'b0;
                    wb3_d   = Wb2;
                    alu_d   = AluRes;
                    rd_d    = toMEMWB;
                    if (!we_q) begin
                        rdata_d = dmem_rdata;
                    end
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    req_d   = 1'b0;
                    err_set = 1'b1;
                    wb3_d   = 2'b00;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    wb3_d = 2'b00;
                end
            end

            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase

        if (err_set) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    always_ff @(posedge clkMEMWB or negedge rstMEMWB_n) begin
        if (!rstMEMWB_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wb3_q   <= '0;
            rdata_q <= '0;
            alu_q   <= '0;
            rd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wb3_q   <= wb3_d;
            rdata_q <= rdata_d;
            alu_q   <= alu_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
        end
    end

    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign Wb3        = wb3_q;
    assign ReadData   = rdata_q;
    assign AluResWB   = alu_q;
    assign rdWB       = rd_q;
    assign bus_err    = err_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb/tb_mem_stage_ctrl.sv - directed self-checking bench for mem_stage_ctrl

module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  Wb2;
    logic        Branch, MemRead, MemWrite, ZFtAND, jump_out, dmem_ack, err_clr;
    logic [31:0] tMux32, AluRes, tWriteData, jaddress_out, dmem_rdata;
    logic [4:0]  toMEMWB;
    logic        dmem_req, dmem_we, PCSrc, stall_mem, bus_err;
    logic [31:0] dmem_addr, dmem_wdata, pc_target, ReadData, AluResWB;
    logic [1:0]  Wb3;
    logic [4:0]  rdWB;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_stage_ctrl #(.TIMEOUT(15), .CNT_W(8)) dut (
        .clkMEMWB(clk), .rstMEMWB_n(rst_n),
        .Wb2(Wb2), .Branch(Branch), .MemRead(MemRead), .MemWrite(MemWrite),
        .tMux32(tMux32), .ZFtAND(ZFtAND), .AluRes(AluRes), .tWriteData(tWriteData),
        .toMEMWB(toMEMWB), .jump_out(jump_out), .jaddress_out(jaddress_out),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .err_clr(err_clr),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .PCSrc(PCSrc), .pc_target(pc_target),
        .stall_mem(stall_mem), .Wb3(Wb3), .ReadData(ReadData),
        .AluResWB(AluResWB), .rdWB(rdWB), .bus_err(bus_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        Wb2 = 2'b00; Branch = 0; MemRead = 0; MemWrite = 0; ZFtAND = 0;
        jump_out = 0; dmem_ack = 0; err_clr = 0;
        tMux32 = 0; AluRes = 0; tWriteData = 0; jaddress_out = 0; dmem_rdata = 0;
        toMEMWB = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        total++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_wdata} !== 66'd0) begin
            bad++; $display("FAIL reset_dmem: got req=%b we=%b addr=%h wdata=%h want all 0",
                            dmem_req, dmem_we, dmem_addr, dmem_wdata);
        end
        total++;
        if ({Wb3, ReadData, AluResWB, rdWB, bus_err, stall_mem} !== 73'd0) begin
            bad++; $display("FAIL reset_memwb: got Wb3=%b rd=%h alu=%h rdWB=%0d err=%b stall=%b want all 0",
                            Wb3, ReadData, AluResWB, rdWB, bus_err, stall_mem);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_passthrough();
        Wb2 = 2'b10; AluRes = 32'h1234_5678; toMEMWB = 5'd9;
        #1;
        total++;
        if (stall_mem !== 1'b0) begin bad++; $display("FAIL pass_stall: got %b want 0", stall_mem); end
        tick();
        total++;
        if (Wb3 !== 2'b10 || AluResWB !== 32'h1234_5678 || rdWB !== 5'd9) begin
            bad++; $display("FAIL pass_memwb: got Wb3=%b alu=%h rdWB=%0d want 10 12345678 9",
                            Wb3, AluResWB, rdWB);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_load_wait();
        int stalls = 0;
        AluRes = 32'h100; MemRead = 1; Wb2 = 2'b11; toMEMWB = 5'd4;
        #1;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) begin dmem_ack = 1; dmem_rdata = 32'hDEAD_BEEF; #1; end
            if (stall_mem) stalls++;
            if (c > 0) begin
                total++;
                if (dmem_req !== 1'b1 || dmem_addr !== 32'h100 || dmem_we !== 1'b0 || Wb3 !== 2'b00) begin
                    bad++; $display("FAIL load_busy%0d: got req=%b addr=%h we=%b Wb3=%b want 1 100 0 00",
                                    c, dmem_req, dmem_addr, dmem_we, Wb3);
                end
            end
            tick();
        end
        dmem_ack = 0; dmem_rdata = 0;
        total++;
        if (ReadData !== 32'hDEAD_BEEF || Wb3 !== 2'b11 || rdWB !== 5'd4 || dmem_req !== 1'b0) begin
            bad++; $display("FAIL load_done: got rd=%h Wb3=%b rdWB=%0d req=%b want deadbeef 11 4 0",
                            ReadData, Wb3, rdWB, dmem_req);
        end
        if (stall_mem) stalls++;
        total++;
        if (stalls !== 4) begin bad++; $display("FAIL load_stall_cycles: got %0d want 4", stalls); end
        tick();
        total++;
        if (Wb3 !== 2'b00 || dmem_req !== 1'b0) begin
            bad++; $display("FAIL load_bubble: got Wb3=%b req=%b want 00 0", Wb3, dmem_req);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_store_ack();
        int stalls = 0;
        MemWrite = 1; AluRes = 32'h200; tWriteData = 32'hA5A5_A5A5; Wb2 = 2'b00;
        #1;
        if (stall_mem) stalls++;
        tick();
        total++;
        if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_wdata !== 32'hA5A5_A5A5 || dmem_addr !== 32'h200) begin
            bad++; $display("FAIL store_req: got req=%b we=%b wdata=%h addr=%h want 1 1 a5a5a5a5 200",
                            dmem_req, dmem_we, dmem_wdata, dmem_addr);
        end
        dmem_ack = 1; dmem_rdata = 32'h1111_1111;
        #1;
        if (stall_mem) stalls++;
        tick();
        dmem_ack = 0;
        if (stall_mem) stalls++;
        total++;
        if (stalls !== 2) begin bad++; $display("FAIL store_stall_cycles: got %0d want 2", stalls); end
        total++;
        if (ReadData !== 32'hDEAD_BEEF || dmem_req !== 1'b0) begin
            bad++; $display("FAIL store_rdata: got rd=%h req=%b want deadbeef 0", ReadData, dmem_req);
        end
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_misaligned();
        MemRead = 1; AluRes = 32'h102; Wb2 = 2'b11; toMEMWB = 5'd7;
        #1;
        total++;
        if (stall_mem !== 1'b0) begin bad++; $display("FAIL mis_stall: got %b want 0", stall_mem); end
        tick();
        total++;
        if (dmem_req !== 1'b0 || bus_err !== 1'b1 || Wb3 !== 2'b00) begin
            bad++; $display("FAIL mis_err: got req=%b err=%b Wb3=%b want 0 1 00", dmem_req, bus_err, Wb3);
        end
        clear_inputs();
        err_clr = 1;
        tick();
        err_clr = 0;
        total++;
        if (bus_err !== 1'b0) begin bad++; $display("FAIL mis_clr: got %b want 0", bus_err); end
        // Set wins over a simultaneous clear.
        MemWrite = 1; AluRes = 32'h3; err_clr = 1;
        tick();
        total++;
        if (bus_err !== 1'b1) begin bad++; $display("FAIL err_set_prio: got %b want 1", bus_err); end
        clear_inputs();
        err_clr = 1;
        tick();
        err_clr = 0;
    endtask

    task automatic test_timeout();
        int n = 0;
        MemRead = 1; AluRes = 32'h300;
        tick();
        for (int i = 0; i < 40; i++) begin
            if (!dmem_req) break;
            n++;
            tick();
        end
        total++;
        if (n !== 15) begin bad++; $display("FAIL timeout_busy_cycles: got %0d want 15", n); end
        total++;
        if (bus_err !== 1'b1 || Wb3 !== 2'b00) begin
            bad++; $display("FAIL timeout_err: got err=%b Wb3=%b want 1 00", bus_err, Wb3);
        end
        tick();
        clear_inputs();
        err_clr = 1;
        tick();
        err_clr = 0;
        total++;
        if (bus_err !== 1'b0) begin bad++; $display("FAIL timeout_clr: got %b want 0", bus_err); end
    endtask

    task automatic test_branch_jump();
        Branch = 1; ZFtAND = 1; tMux32 = 32'h40;
        #1;
        total++;
        if (PCSrc !== 1'b1 || pc_target !== 32'h40) begin
            bad++; $display("FAIL branch_taken: got PCSrc=%b tgt=%h want 1 40", PCSrc, pc_target);
        end
        jump_out = 1; jaddress_out = 32'h80;
        #1;
        total++;
        if (PCSrc !== 1'b1 || pc_target !== 32'h80) begin
            bad++; $display("FAIL jump_prio: got PCSrc=%b tgt=%h want 1 80", PCSrc, pc_target);
        end
        jump_out = 0; ZFtAND = 0;
        #1;
        total++;
        if (PCSrc !== 1'b0) begin bad++; $display("FAIL branch_not_taken: got %b want 0", PCSrc); end
        clear_inputs();
        tick();
    endtask

    task automatic test_reset_mid_access();
        MemRead = 1; AluRes = 32'h10; Wb2 = 2'b11;
        tick();
        tick();
        tick();
        total++;
        if (dmem_req !== 1'b1) begin bad++; $display("FAIL rmid_req_before: got %b want 1", dmem_req); end
        #2;
        rst_n = 1'b0;
        clear_inputs();
        #1;
        total++;
        if ({dmem_req, dmem_addr, Wb3, bus_err, stall_mem} !== 37'd0) begin
            bad++; $display("FAIL rmid_async: got req=%b addr=%h Wb3=%b err=%b stall=%b want all 0",
                            dmem_req, dmem_addr, Wb3, bus_err, stall_mem);
        end
        tick();
        rst_n = 1'b1;
        dmem_ack = 1; dmem_rdata = 32'hCAFE_0000;
        tick();
        dmem_ack = 0;
        total++;
        if (dmem_req !== 1'b0 || ReadData !== 32'd0 || stall_mem !== 1'b0) begin
            bad++; $display("FAIL rmid_late_ack: got req=%b rd=%h stall=%b want 0 0 0",
                            dmem_req, ReadData, stall_mem);
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_load_wait();
        test_store_ack();
        test_misaligned();
        test_timeout();
        test_branch_jump();
        test_reset_mid_access();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
